// File: rtl/ball_motion_engine_if.sv
// Signal bundle between the frame-timing logic and the ball motion engine.
// master drives frame strobe, pause and speeds; slave publishes the committed ball state.
interface ball_motion_engine_if;
    logic       frame_tick;
    logic       pause;
    logic [2:0] speed_x;
    logic [2:0] speed_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       dir_x;
    logic       dir_y;
    logic       pos_valid;
    logic       busy;
    logic [7:0] bounce_count;
    logic       overrun;

    modport master (
        output frame_tick, pause, speed_x, speed_y,
        input  ball_x, ball_y, dir_x, dir_y, pos_valid, busy, bounce_count, overrun
    );

    modport slave (
        input  frame_tick, pause, speed_x, speed_y,
        output ball_x, ball_y, dir_x, dir_y, pos_valid, busy, bounce_count, overrun
    );
endinterface

// File: rtl/ball_motion_engine.sv
// Per-frame ball motion: multi-cycle X/Y step with wall clamping, atomic commit, bounce counter.
// Optional BALL_GRAVITY_EN: vertical speed accelerates downward and decelerates upward.
//
// state  | meaning
// IDLE   | waiting for an accepted frame_tick
// CALC_X | computing next X position / direction
// CALC_Y | computing next Y position / direction
// COMMIT | publishing new position, direction and bounce count together
module ball_motion_engine #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BALL_SIZE = 20,
    parameter int INIT_X    = 320,
    parameter int INIT_Y    = 240
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ball_motion_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

    localparam logic [10:0] X_LO  = 11'(BALL_SIZE);
    localparam logic [10:0] X_HI  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_LO  = 11'(BALL_SIZE);
    localparam logic [10:0] Y_HI  = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0]  RST_X = 10'(INIT_X);
    localparam logic [9:0]  RST_Y = 10'(INIT_Y);

    state_t      state_q, state_d;
    logic        accept;
    logic        tick_while_busy;
    logic [9:0]  ball_x_q, ball_y_q, nx_q, ny_q;
    logic        dir_x_q, dir_y_q, ndir_x_q, ndir_y_q, hit_x_q, hit_y_q;
    logic        pos_valid_q, busy_q, overrun_q;
    logic [7:0]  bounce_q;
    logic [2:0]  sx_q, sy_eff;
    logic [11:0] step_x, step_y;
    logic [8:0]  bsum;

    // Returns {hit, new_dir, new_pos[9:0]}; 11-bit math keeps the sum from wrapping.
    function automatic logic [11:0] axis_step(input logic [10:0] pos, input logic dir,
                                              input logic [2:0] spd, input logic [10:0] lo,
                                              input logic [10:0] hi);
        logic [10:0] sp, sum, dif;
        sp  = {8'd0, spd};
        sum = pos + sp;
        dif = pos - sp;
        if (dir) begin
            if (sum >= hi) axis_step = {1'b1, 1'b0, hi[9:0]};
            else           axis_step = {1'b0, 1'b1, sum[9:0]};
        end else begin
            if ((pos < lo + sp) || (dif <= lo)) axis_step = {1'b1, 1'b1, lo[9:0]};
            else                                axis_step = {1'b0, 1'b0, dif[9:0]};
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_tick && !bus.pause && !busy_q) begin
                    accept  = 1'b1;
                    state_d = CALC_X;
                end
            end
            CALC_X:  state_d = CALC_Y;
            CALC_Y:  state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy_q stays high through the pos_valid cycle, so a tick there is an overrun too.
    assign tick_while_busy = bus.frame_tick && ((state_q != IDLE) || busy_q);
    assign step_x = axis_step({1'b0, ball_x_q}, dir_x_q, sx_q, X_LO, X_HI);
    assign step_y = axis_step({1'b0, ball_y_q}, dir_y_q, sy_eff, Y_LO, Y_HI);
    assign bsum   = {1'b0, bounce_q} + {8'd0, hit_x_q} + {8'd0, hit_y_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_x_q    <= RST_X;
            ball_y_q    <= RST_Y;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            nx_q        <= RST_X;
            ny_q        <= RST_Y;
            ndir_x_q    <= 1'b1;
            ndir_y_q    <= 1'b1;
            hit_x_q     <= 1'b0;
            hit_y_q     <= 1'b0;
            sx_q        <= 3'd0;
            pos_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            bounce_q    <= 8'd0;
        end else begin
            pos_valid_q <= 1'b0;
            busy_q      <= (state_q != IDLE);
            if (tick_while_busy) overrun_q <= 1'b1;
            if (accept)          sx_q      <= bus.speed_x;
            if (state_q == CALC_X) {hit_x_q, ndir_x_q, nx_q} <= step_x;
            if (state_q == CALC_Y) {hit_y_q, ndir_y_q, ny_q} <= step_y;
            if (state_q == COMMIT) begin
                ball_x_q    <= nx_q;
                ball_y_q    <= ny_q;
                dir_x_q     <= ndir_x_q;
                dir_y_q     <= ndir_y_q;
                pos_valid_q <= 1'b1;
                bounce_q    <= bsum[8] ? 8'hFF : bsum[7:0];
            end
        end
    end

`ifdef BALL_GRAVITY_EN
    logic [2:0] vy_q;
    logic       vy_init_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vy_q      <= 3'd0;
            vy_init_q <= 1'b0;
        end else if (!vy_init_q) begin
            vy_q      <= bus.speed_y;
            vy_init_q <= 1'b1;
        end else if (state_q == COMMIT) begin
            // A Y hit that turns the ball downward is the top wall.
            if (hit_y_q && ndir_y_q) vy_q <= bus.speed_y;
            else if (ndir_y_q)       vy_q <= (vy_q == 3'd7) ? 3'd7 : vy_q + 3'd1;
            else                     vy_q <= (vy_q <= 3'd1) ? 3'd1 : vy_q - 3'd1;
        end
    end

    assign sy_eff = vy_q;
`else
    logic [2:0] sy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sy_q <= 3'd0;
        else if (accept) sy_q <= bus.speed_y;
    end

    assign sy_eff = sy_q;
`endif

    assign bus.ball_x       = ball_x_q;
    assign bus.ball_y       = ball_y_q;
    assign bus.dir_x        = dir_x_q;
    assign bus.dir_y        = dir_y_q;
    assign bus.pos_valid    = pos_valid_q;
    assign bus.busy         = busy_q;
    assign bus.bounce_count = bounce_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine: reset, latency, wall bounces, pause, overrun,
// mid-update reset and bounce counter saturation.
module tb_ball_motion_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   tmo = 0;

    always #5 clk = ~clk;

    ball_motion_engine_if bus();

    ball_motion_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic apply_reset();
        bus.frame_tick = 1'b0;
        bus.pause      = 1'b0;
        bus.speed_x    = 3'd0;
        bus.speed_y    = 3'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One accepted frame; lat = negedges after the accepting edge until pos_valid, -1 if never.
    task automatic do_frame(input logic [2:0] sx, input logic [2:0] sy, output int lat);
        bus.speed_x    = sx;
        bus.speed_y    = sy;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.pos_valid) begin
                lat = i;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_frames(input int n, input logic [2:0] sx, input logic [2:0] sy);
        int lat;
        for (int k = 0; k < n; k++) begin
            do_frame(sx, sy, lat);
            if (lat != 3) tmo++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.ball_x !== 10'd320) begin bad++; $display("FAIL reset_x got=%0d want=320", bus.ball_x); end
        total++; if (bus.ball_y !== 10'd240) begin bad++; $display("FAIL reset_y got=%0d want=240", bus.ball_y); end
        total++; if ({bus.dir_x, bus.dir_y} !== 2'b11) begin bad++; $display("FAIL reset_dir got=%b want=11", {bus.dir_x, bus.dir_y}); end
        total++; if ({bus.pos_valid, bus.busy, bus.overrun} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.pos_valid, bus.busy, bus.overrun}); end
        total++; if (bus.bounce_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.bounce_count); end
    endtask

    task automatic test_basic();
        apply_reset();
        bus.speed_x = 3'd2; bus.speed_y = 3'd2; bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        total++; if ({bus.busy, bus.pos_valid} !== 2'b10) begin bad++; $display("FAIL basic_n1 busy,pv got=%b want=10", {bus.busy, bus.pos_valid}); end
        @(negedge clk);
        total++; if ({bus.busy, bus.pos_valid, bus.ball_x} !== {2'b10, 10'd320}) begin bad++; $display("FAIL basic_n2 busy,pv,x got=%b,%0d want=10,320", {bus.busy, bus.pos_valid}, bus.ball_x); end
        @(negedge clk);
        total++; if ({bus.busy, bus.pos_valid} !== 2'b11) begin bad++; $display("FAIL basic_n3 busy,pv got=%b want=11", {bus.busy, bus.pos_valid}); end
        total++; if (bus.ball_x !== 10'd322 || bus.ball_y !== 10'd242) begin bad++; $display("FAIL basic_pos got=%0d,%0d want=322,242", bus.ball_x, bus.ball_y); end
        total++; if ({bus.dir_x, bus.dir_y} !== 2'b11 || bus.bounce_count !== 8'd0) begin bad++; $display("FAIL basic_dir_cnt got=%b,%0d want=11,0", {bus.dir_x, bus.dir_y}, bus.bounce_count); end
        @(negedge clk);
        total++; if ({bus.busy, bus.pos_valid} !== 2'b00) begin bad++; $display("FAIL basic_n4 busy,pv got=%b want=00", {bus.busy, bus.pos_valid}); end
    endtask

    task automatic test_x_wall();
        apply_reset();
        tmo = 0;
        run_frames(42, 3'd7, 3'd0);
        total++; if (bus.ball_x !== 10'd614) begin bad++; $display("FAIL xwall_42 x got=%0d want=614", bus.ball_x); end
        run_frames(1, 3'd7, 3'd0);
        total++; if (bus.ball_x !== 10'd620 || bus.dir_x !== 1'b0) begin bad++; $display("FAIL xwall_43 x,dir got=%0d,%b want=620,0", bus.ball_x, bus.dir_x); end
        total++; if (bus.bounce_count !== 8'd1 || bus.ball_y !== 10'd240) begin bad++; $display("FAIL xwall_43 cnt,y got=%0d,%0d want=1,240", bus.bounce_count, bus.ball_y); end
        total++; if (tmo !== 0) begin bad++; $display("FAIL xwall_timeouts got=%0d want=0", tmo); end
    endtask

    task automatic test_xy_walls();
        apply_reset();
        tmo = 0;
        run_frames(32, 3'd7, 3'd7);
        total++; if ({bus.ball_x, bus.ball_y} !== {10'd544, 10'd460}) begin bad++; $display("FAIL xy_32 pos got=%0d,%0d want=544,460", bus.ball_x, bus.ball_y); end
        total++; if (bus.dir_y !== 1'b0 || bus.bounce_count !== 8'd1) begin bad++; $display("FAIL xy_32 dir_y,cnt got=%b,%0d want=0,1", bus.dir_y, bus.bounce_count); end
        run_frames(11, 3'd7, 3'd7);
        total++; if ({bus.ball_x, bus.ball_y} !== {10'd620, 10'd383}) begin bad++; $display("FAIL xy_43 pos got=%0d,%0d want=620,383", bus.ball_x, bus.ball_y); end
        total++; if (bus.dir_x !== 1'b0 || bus.bounce_count !== 8'd2) begin bad++; $display("FAIL xy_43 dir_x,cnt got=%b,%0d want=0,2", bus.dir_x, bus.bounce_count); end
        total++; if (tmo !== 0) begin bad++; $display("FAIL xy_timeouts got=%0d want=0", tmo); end
    endtask

    task automatic test_pause();
        int pv_cnt;
        int busy_cnt;
        apply_reset();
        pv_cnt = 0; busy_cnt = 0;
        bus.pause = 1'b1; bus.speed_x = 3'd5; bus.speed_y = 3'd5;
        for (int t = 0; t < 5; t++) begin
            bus.frame_tick = 1'b1;
            @(negedge clk);
            bus.frame_tick = 1'b0;
            for (int c = 0; c < 5; c++) begin
                if (bus.pos_valid) pv_cnt++;
                if (bus.busy) busy_cnt++;
                @(negedge clk);
            end
        end
        total++; if (pv_cnt !== 0 || busy_cnt !== 0) begin bad++; $display("FAIL pause_quiet pv,busy got=%0d,%0d want=0,0", pv_cnt, busy_cnt); end
        total++; if (bus.ball_x !== 10'd320 || bus.overrun !== 1'b0) begin bad++; $display("FAIL pause_state x,ovr got=%0d,%b want=320,0", bus.ball_x, bus.overrun); end
        // pause raised after acceptance must not cancel the update in flight
        bus.pause = 1'b0; bus.speed_x = 3'd3; bus.speed_y = 3'd0; bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0; bus.pause = 1'b1;
        pv_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.pos_valid) pv_cnt++;
        end
        bus.pause = 1'b0;
        total++; if (pv_cnt !== 1 || bus.ball_x !== 10'd323) begin bad++; $display("FAIL pause_midcalc pv,x got=%0d,%0d want=1,323", pv_cnt, bus.ball_x); end
    endtask

    task automatic test_back_to_back();
        int pv_cnt;
        int lat;
        apply_reset();
        bus.speed_x = 3'd2; bus.speed_y = 3'd1; bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.speed_x = 3'd7; bus.speed_y = 3'd7;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        pv_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.pos_valid) pv_cnt++;
            @(negedge clk);
        end
        total++; if (pv_cnt !== 1) begin bad++; $display("FAIL b2b_pulses got=%0d want=1", pv_cnt); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b want=1", bus.overrun); end
        total++; if ({bus.ball_x, bus.ball_y} !== {10'd322, 10'd241}) begin bad++; $display("FAIL b2b_latched_speed got=%0d,%0d want=322,241", bus.ball_x, bus.ball_y); end
        do_frame(3'd1, 3'd1, lat);
        total++; if (lat !== 3 || bus.ball_x !== 10'd323 || bus.overrun !== 1'b1) begin bad++; $display("FAIL b2b_next lat,x,ovr got=%0d,%0d,%b want=3,323,1", lat, bus.ball_x, bus.overrun); end
    endtask

    task automatic test_reset_midcalc();
        int pv_cnt;
        apply_reset();
        tmo = 0;
        run_frames(32, 3'd7, 3'd7);
        total++; if (bus.dir_y !== 1'b0 || bus.bounce_count !== 8'd1 || tmo !== 0) begin bad++; $display("FAIL midrst_pre dir_y,cnt,tmo got=%b,%0d,%0d want=0,1,0", bus.dir_y, bus.bounce_count, tmo); end
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        total++; if ({bus.ball_x, bus.ball_y} !== {10'd320, 10'd240}) begin bad++; $display("FAIL midrst_pos got=%0d,%0d want=320,240", bus.ball_x, bus.ball_y); end
        total++; if ({bus.dir_x, bus.dir_y, bus.busy, bus.pos_valid} !== 4'b1100 || bus.bounce_count !== 8'd0) begin bad++; $display("FAIL midrst_flags dx,dy,busy,pv got=%b cnt=%0d want=1100 cnt=0", {bus.dir_x, bus.dir_y, bus.busy, bus.pos_valid}, bus.bounce_count); end
        @(negedge clk);
        rst_n = 1'b1;
        pv_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.pos_valid || bus.busy) pv_cnt++;
        end
        total++; if (pv_cnt !== 0 || bus.ball_x !== 10'd320) begin bad++; $display("FAIL midrst_after pv/busy_cycles,x got=%0d,%0d want=0,320", pv_cnt, bus.ball_x); end
    endtask

    // Corner-to-corner trips: 62 diagonal frames, 23 X-only, then one frame hitting both walls.
    task automatic test_corner_saturate();
        apply_reset();
        tmo = 0;
        run_frames(31, 3'd7, 3'd7);
        run_frames(11, 3'd7, 3'd0);
        run_frames(1, 3'd7, 3'd7);
        total++; if ({bus.ball_x, bus.ball_y, bus.bounce_count} !== {10'd620, 10'd460, 8'd2}) begin bad++; $display("FAIL corner_first x,y,cnt got=%0d,%0d,%0d want=620,460,2", bus.ball_x, bus.ball_y, bus.bounce_count); end
        for (int t = 0; t < 126; t++) begin
            run_frames(62, 3'd7, 3'd7);
            run_frames(23, 3'd7, 3'd0);
            run_frames(1, 3'd7, 3'd7);
        end
        total++; if ({bus.ball_x, bus.ball_y, bus.bounce_count} !== {10'd620, 10'd460, 8'd254}) begin bad++; $display("FAIL corner_254 x,y,cnt got=%0d,%0d,%0d want=620,460,254", bus.ball_x, bus.ball_y, bus.bounce_count); end
        run_frames(62, 3'd7, 3'd7);
        run_frames(23, 3'd7, 3'd0);
        run_frames(1, 3'd7, 3'd7);
        total++; if ({bus.ball_x, bus.ball_y, bus.bounce_count} !== {10'd20, 10'd20, 8'd255}) begin bad++; $display("FAIL corner_sat x,y,cnt got=%0d,%0d,%0d want=20,20,255", bus.ball_x, bus.ball_y, bus.bounce_count); end
        total++; if ({bus.dir_x, bus.dir_y} !== 2'b11) begin bad++; $display("FAIL corner_sat_dir got=%b want=11", {bus.dir_x, bus.dir_y}); end
        run_frames(62, 3'd7, 3'd7);
        run_frames(23, 3'd7, 3'd0);
        run_frames(1, 3'd7, 3'd7);
        total++; if (bus.bounce_count !== 8'd255 || bus.ball_x !== 10'd620) begin bad++; $display("FAIL corner_hold cnt,x got=%0d,%0d want=255,620", bus.bounce_count, bus.ball_x); end
        total++; if (tmo !== 0) begin bad++; $display("FAIL corner_timeouts got=%0d want=0", tmo); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x_wall();
        test_xy_walls();
        test_pause();
        test_back_to_back();
        test_reset_midcalc();
        test_corner_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
Upstream stage of the VGA ball renderer. It owns the ball state (position, direction, bounce count) and advances it once per frame on a start-of-frame strobe. Coordinates are published atomically, so the per-pixel distance/shadow logic downstream never sees a half-updated position. Motion uses a small multi-cycle FSM with wall clamping and a bounce counter.

Parameters:
H_ACTIVE, 640, visible width in pixels
V_ACTIVE, 480, visible height in pixels
BALL_SIZE, 20, ball radius; sets the wall margins
INIT_X, 320, reset X centre
INIT_Y, 240, reset Y centre

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle start-of-frame strobe (hpos==0 && vpos==0)
pause  input  1  freezes motion while high
speed_x  input  3  X pixels per frame, 0..7
speed_y  input  3  Y pixels per frame, 0..7
ball_x  output  10  committed X centre
ball_y  output  10  committed Y centre
dir_x  output  1  1=right, 0=left
dir_y  output  1  1=down, 0=up
pos_valid  output  1  one-cycle pulse when a new position is committed
busy  output  1  FSM not in IDLE
bounce_count  output  8  wall hits, saturating at 255
overrun  output  1  sticky flag: frame_tick arrived while busy

Behaviour:
- Single clock domain is clk. Reset is asynchronous and active-low on rst_n; all flops clear immediately on its assertion.
- Reset values:
  - ball_x=INIT_X, ball_y=INIT_Y.
  - dir_x=1, dir_y=1.
  - pos_valid=0, busy=0, bounce_count=0, overrun=0.
  - FSM state = IDLE.
- FSM states: IDLE -> CALC_X -> CALC_Y -> COMMIT -> IDLE.
- IDLE:
  - frame_tick=1 and pause=0: latch speed_x/speed_y into shadow regs, go to CALC_X.
  - frame_tick=1 and pause=1: stay in IDLE; no pos_valid pulse, nothing changes.
- CALC_X: compute nx in 11-bit unsigned.
  - Right (dir_x=1): nx=ball_x+sx. If nx >= H_ACTIVE-BALL_SIZE: nx=H_ACTIVE-BALL_SIZE, ndir_x=0, hit_x=1.
  - Left (dir_x=0): if ball_x < BALL_SIZE+sx, or ball_x-sx <= BALL_SIZE: nx=BALL_SIZE, ndir_x=1, hit_x=1. Otherwise nx=ball_x-sx.
  - The subtraction never underflows.
- CALC_Y: same rules against V_ACTIVE-BALL_SIZE and BALL_SIZE, producing ny, ndir_y, hit_y.
- COMMIT:
  - ball_x, ball_y, dir_x, dir_y update together in this one cycle.
  - pos_valid=1 for exactly this cycle.
  - bounce_count += hit_x + hit_y, saturating at 255; a corner hit adds 2.
- Latency: frame_tick sampled at edge N; ball_x/ball_y/dir/pos_valid change at edge N+3.
- busy is high from N+1 through the pos_valid cycle inclusive.
- frame_tick while busy: ignored and overrun set to 1. overrun clears only on reset.
- pause asserted mid-calculation does not abort the update in flight.
- Speed 0 on an axis: position unchanged. A ball already sitting on a wall still satisfies the >= / <= check, so it is re-clamped, flipped and counted.
- Speed inputs are sampled only on the accepting frame_tick; changes while busy take effect on the next frame.
- Reset asserted mid-FSM: immediate return to reset values. No pos_valid glitch after release.

Optional Feature:
Macro BALL_GRAVITY_EN.
- Defined:
  - An internal vy register (3 bits) replaces the latched speed_y. It loads from speed_y at reset release and on every top-wall bounce.
  - Each COMMIT: dir_y=1 gives vy=min(vy+1,7); dir_y=0 gives vy=max(vy-1,1).
  - Wall clamping rules are unchanged.
- Not defined: vertical speed is the latched speed_y, constant per frame, and no vy register exists.

Test Plan:
- Reset release, then frame_tick with speed_x=2, speed_y=2 -> after 3 cycles pos_valid=1 for 1 cycle, ball_x=322, ball_y=242, dir 1/1, bounce_count=0.
- speed_x=7, speed_y=0, 42 ticks -> ball_x=614. Tick 43 -> ball_x=620, dir_x=0, bounce_count=1, ball_y stays 240.
- speed_x=7, speed_y=7 from reset -> tick 32 gives ball_y=460, dir_y=0, count=1. Tick 43 gives ball_x=620, dir_x=0, count=2.
- pause=1 with 5 frame_ticks -> no pos_valid, ball_x=320, busy stays 0. A second frame_tick one cycle after an accepted one -> overrun=1 and only one pos_valid pulse.
- rst_n pulled low in the CALC_Y cycle -> outputs return to 320/240/1/1 asynchronously, busy=0, no pos_valid after release.
- Corner case: bounce_count preset to 254 via 254 wall hits, then a corner hit -> bounce_count=255, no wrap.
